// File: rtl/seg_disp_sched.sv
// Display scheduler for the 8-digit seven-segment driver: live value with blink, timed messages, blank gap.
// Latency: one sclk from inputs/next state to dig_*; msg_ready low only while the post-message blank runs.
// Optional leading-zero blanking of the live value is enabled by defining SEG_LZ_BLANK_EN.
module seg_disp_sched #(
    parameter int CLK_PER_MS  = 50000,
    parameter int MSG_HOLD_MS = 2000,
    parameter int BLINK_MS    = 500
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic [31:0] live_data,
    input  logic [7:0]  blink_mask,
    input  logic [31:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        msg_busy,
    output logic [3:0]  dig_7,
    output logic [3:0]  dig_6,
    output logic [3:0]  dig_5,
    output logic [3:0]  dig_4,
    output logic [3:0]  dig_3,
    output logic [3:0]  dig_2,
    output logic [3:0]  dig_1,
    output logic [3:0]  dig_0
);

    localparam int PW = (CLK_PER_MS  > 1) ? $clog2(CLK_PER_MS)  : 1;
    localparam int MW = (MSG_HOLD_MS > 1) ? $clog2(MSG_HOLD_MS) : 1;
    localparam int BW = (BLINK_MS    > 1) ? $clog2(BLINK_MS)    : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_MS - 1);
    localparam logic [MW-1:0] HOLD_LAST  = MW'(MSG_HOLD_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
    localparam logic [3:0]    BLANK      = 4'hA;

    typedef enum logic [1:0] {
        ST_LIVE  = 2'd0,
        ST_MSG   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic [PW-1:0]   bpre_q, bpre_d;
    logic [BW-1:0]   bms_q, bms_d;
    logic            phase_q, phase_d;
    logic [7:0][3:0] msg_buf_q, msg_buf_d;
    logic [7:0][3:0] dig_q, dig_d;
    logic            msg_ready_q, msg_ready_d;
    logic            msg_busy_q, msg_busy_d;

    logic            accept;
    logic [7:0][3:0] live_v;
    logic [7:0][3:0] live_disp;

    assign accept = msg_valid && msg_ready_q;
    assign live_v = live_data;

    // Hold/clear timer and FSM next state.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        ms_d      = ms_q;
        msg_buf_d = msg_buf_q;
        if (accept) begin
            state_d   = ST_MSG;
            pre_d     = '0;
            ms_d      = '0;
            msg_buf_d = msg_data;
        end else begin
            case (state_q)
                ST_LIVE: begin
                    pre_d = '0;
                    ms_d  = '0;
                end
                ST_MSG: begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (ms_q == HOLD_LAST) begin
                            ms_d    = '0;
                            state_d = ST_CLEAR;
                        end else begin
                            ms_d = ms_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    ms_d = '0;
                    if (pre_q == PRE_LAST) begin
                        pre_d   = '0;
                        state_d = ST_LIVE;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LIVE;
                    pre_d   = '0;
                    ms_d    = '0;
                end
            endcase
        end
    end

    // Free-running blink phase, independent of the FSM.
    always_comb begin
        bpre_d  = bpre_q + 1'b1;
        bms_d   = bms_q;
        phase_d = phase_q;
        if (bpre_q == PRE_LAST) begin
            bpre_d = '0;
            if (bms_q == BLINK_LAST) begin
                bms_d   = '0;
                phase_d = ~phase_q;
            end else begin
                bms_d = bms_q + 1'b1;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_run    = 1'b1;
        live_disp = live_v;
        for (int i = 7; i >= 1; i--) begin
            if (lz_run && (live_v[i] == 4'h0)) begin
                live_disp[i] = BLANK;
            end else begin
                lz_run = 1'b0;
            end
        end
    end
`else
    always_comb begin
        live_disp = live_v;
    end
`endif

    // Outputs track the state being entered so data and msg_busy change on the same edge.
    always_comb begin
        dig_d       = '0;
        msg_ready_d = (state_d != ST_CLEAR);
        msg_busy_d  = (state_d == ST_MSG);
        for (int i = 0; i < 8; i++) begin
            case (state_d)
                ST_LIVE: dig_d[i] = (blink_mask[i] && phase_d) ? BLANK : live_disp[i];
                ST_MSG:  dig_d[i] = msg_buf_d[i];
                default: dig_d[i] = BLANK;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_LIVE;
            pre_q       <= '0;
            ms_q        <= '0;
            bpre_q      <= '0;
            bms_q       <= '0;
            phase_q     <= 1'b0;
            msg_buf_q   <= {8{BLANK}};
            dig_q       <= {8{BLANK}};
            msg_ready_q <= 1'b0;
            msg_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            ms_q        <= ms_d;
            bpre_q      <= bpre_d;
            bms_q       <= bms_d;
            phase_q     <= phase_d;
            msg_buf_q   <= msg_buf_d;
            dig_q       <= dig_d;
            msg_ready_q <= msg_ready_d;
            msg_busy_q  <= msg_busy_d;
        end
    end

    assign msg_ready = msg_ready_q;
    assign msg_busy  = msg_busy_q;
    assign dig_7     = dig_q[7];
    assign dig_6     = dig_q[6];
    assign dig_5     = dig_q[5];
    assign dig_4     = dig_q[4];
    assign dig_3     = dig_q[3];
    assign dig_2     = dig_q[2];
    assign dig_1     = dig_q[1];
    assign dig_0     = dig_q[0];

endmodule

// File: tb/tb_seg_disp_sched.sv
// Bench for seg_disp_sched: directed scenarios plus random traffic against a countdown-based reference model.
module tb_seg_disp_sched;

    localparam int CPM   = 10;
    localparam int HOLD  = 3;
    localparam int BLINK = 2;

    logic        sclk;
    logic        nrst;
    logic [31:0] live_data;
    logic [7:0]  blink_mask;
    logic [31:0] msg_data;
    logic        msg_valid;
    logic        msg_ready;
    logic        msg_busy;
    logic [3:0]  dig_7, dig_6, dig_5, dig_4, dig_3, dig_2, dig_1, dig_0;

    int checks = 0;
    int errors = 0;

    seg_disp_sched #(
        .CLK_PER_MS (CPM),
        .MSG_HOLD_MS(HOLD),
        .BLINK_MS   (BLINK)
    ) dut (
        .sclk      (sclk),
        .nrst      (nrst),
        .live_data (live_data),
        .blink_mask(blink_mask),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_busy  (msg_busy),
        .dig_7     (dig_7),
        .dig_6     (dig_6),
        .dig_5     (dig_5),
        .dig_4     (dig_4),
        .dig_3     (dig_3),
        .dig_2     (dig_2),
        .dig_1     (dig_1),
        .dig_0     (dig_0)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: mode 0=live, 1=message, 2=blank gap; m_left counts remaining cycles.
    int          m_mode;
    int          m_left;
    int          m_edges;
    logic [31:0] m_buf;
    logic [31:0] m_dig;
    bit          m_ready;
    bit          m_busy;

    function automatic logic [31:0] exp_live(input logic [31:0] d, input logic [7:0] m, input bit ph);
        logic [31:0] r;
        int top;
        r   = d;
        top = 0;
        for (int i = 0; i < 8; i++)
            if (d[i*4 +: 4] != 4'h0) top = i;
`ifdef SEG_LZ_BLANK_EN
        for (int i = 1; i < 8; i++)
            if (i > top) r[i*4 +: 4] = 4'hA;
`endif
        for (int i = 0; i < 8; i++)
            if (m[i] && ph) r[i*4 +: 4] = 4'hA;
        return r;
    endfunction

    always @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            m_mode  = 0;
            m_left  = 0;
            m_edges = 0;
            m_buf   = 32'hAAAA_AAAA;
            m_dig   = 32'hAAAA_AAAA;
            m_ready = 1'b0;
            m_busy  = 1'b0;
        end else begin
            bit ph;
            if (msg_valid && m_ready) begin
                m_mode = 1;
                m_left = HOLD * CPM;
                m_buf  = msg_data;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2;
                    m_left = CPM;
                end
            end else if (m_mode == 2) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            m_edges++;
            ph      = ((m_edges / (BLINK * CPM)) % 2) == 1;
            m_ready = (m_mode != 2);
            m_busy  = (m_mode == 1);
            m_dig   = (m_mode == 0) ? exp_live(live_data, blink_mask, ph) :
                      (m_mode == 1) ? m_buf : 32'hAAAA_AAAA;
        end
    end

    function automatic logic [31:0] dig_all();
        return {dig_7, dig_6, dig_5, dig_4, dig_3, dig_2, dig_1, dig_0};
    endfunction

    task automatic cycle();
        @(negedge sclk);
        check("dig", dig_all(), m_dig);
        check("ready", {31'b0, msg_ready}, {31'b0, m_ready});
        check("busy", {31'b0, msg_busy}, {31'b0, m_busy});
    endtask

    function automatic logic [31:0] rnd_live();
        logic [31:0] r;
        int lead;
        r    = $urandom;
        lead = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i >= 8 - lead) r[i*4 +: 4] = 4'h0;
            else if ($urandom_range(0, 3) == 0) r[i*4 +: 4] = 4'h0;
        end
        return r;
    endfunction

    initial begin
        logic [31:0] m2;
        nrst       = 1'b0;
        live_data  = 32'h0000_1234;
        blink_mask = 8'h00;
        msg_data   = 32'h0;
        msg_valid  = 1'b0;

        // Reset values
        repeat (3) cycle();
        check("rst_dig", dig_all(), 32'hAAAA_AAAA);
        check("rst_ready", {31'b0, msg_ready}, 32'd0);
        nrst = 1'b1;
        cycle();
        check("first_ready", {31'b0, msg_ready}, 32'd1);
`ifdef SEG_LZ_BLANK_EN
        check("live_1234", dig_all(), 32'hAAAA_1234);
`else
        check("live_1234", dig_all(), 32'h0000_1234);
`endif

        // Message, hold, blank gap, back to live
        msg_data  = 32'hDCBA_9876;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        check("msg_shown", dig_all(), 32'hDCBA_9876);
        check("msg_busy", {31'b0, msg_busy}, 32'd1);
        repeat (29) cycle();
        check("msg_last", dig_all(), 32'hDCBA_9876);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("clear_dig", dig_all(), 32'hAAAA_AAAA);
            check("clear_ready", {31'b0, msg_ready}, 32'd0);
        end
        cycle();
        check("live_back_busy", {31'b0, msg_busy}, 32'd0);
        check("live_back_ready", {31'b0, msg_ready}, 32'd1);

        // Preemption 20 cycles into a message
        msg_data  = 32'h1111_2222;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        repeat (19) cycle();
        m2        = 32'h3456_CDEF;
        msg_data  = m2;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        check("preempt_dig", dig_all(), m2);
        for (int k = 0; k < 29; k++) begin
            cycle();
            check("preempt_hold", {31'b0, msg_busy}, 32'd1);
        end
        cycle();
        check("preempt_clear", {31'b0, msg_ready}, 32'd0);
        repeat (10) cycle();

        // Offer landing on the expiry edge
        msg_data  = 32'h7777_7777;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        repeat (29) cycle();
        msg_data  = 32'h5432_10FE;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        check("expiry_acc_dig", dig_all(), 32'h5432_10FE);
        check("expiry_acc_ready", {31'b0, msg_ready}, 32'd1);
        check("expiry_acc_busy", {31'b0, msg_busy}, 32'd1);
        repeat (40) cycle();

        // Blink on digit 0, then message ignores blink
        live_data  = 32'h1111_1111;
        blink_mask = 8'h01;
        repeat (60) cycle();
        msg_data  = 32'h9999_9991;
        msg_valid = 1'b1;
        cycle();
        msg_valid = 1'b0;
        repeat (25) cycle();

        // Reset mid-message
        nrst = 1'b0;
        cycle();
        check("midrst_dig", dig_all(), 32'hAAAA_AAAA);
        check("midrst_busy", {31'b0, msg_busy}, 32'd0);
        repeat (2) cycle();
        nrst = 1'b1;
        cycle();
        check("postrst_ready", {31'b0, msg_ready}, 32'd1);
        check("postrst_dig0", {28'b0, dig_0}, 32'd1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) live_data = rnd_live();
            if ($urandom_range(0, 49) == 0) blink_mask = $urandom_range(0, 255);
            msg_valid = ($urandom_range(0, 14) == 0);
            msg_data  = $urandom;
            cycle();
        end
        msg_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
